if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC, drives the instruction SRAM read port and produces the IF-to-ID bus.
- Consumes the branch bus resolved in ID and the global stall vector. It is the producer end of the IF/ID and branch interfaces.
- Adds a pending-redirect latch so a branch resolved while IF is stalled is never lost.

Parameters:
- RESET_PC, 32'hBFBF_FFFC, PC value held during reset; the first real fetch is RESET_PC+4 = 32'hBFC0_0000.
- STALL_WD, 6, width of the stall vector (StallBus).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  STALL_WD  global stall vector; bit 0 = 1 (Stop) freezes the PC
- br_bus  in  33  {br_e[32], br_addr[31:0]} from ID; taken branch/jump and its target
- inst_sram_en  out  1  SRAM read enable
- inst_sram_wen  out  4  SRAM byte write enables; constant 4'b0000
- inst_sram_addr  out  32  SRAM address (= current PC)
- inst_sram_wdata  out  32  constant 32'h0
- if_to_id_bus  out  33  {ce[32], pc[31:0]}, sampled by ID on the next edge
- fetch_adel  out  1  current PC is not word aligned (address-error flag to ID)

Behaviour:
- Registers: pc_r[31:0], ce_r, pend_v, pend_addr[31:0].
- Reset (rst_n=0, asynchronous, any time including mid-stall):
  - pc_r=RESET_PC, ce_r=0, pend_v=0, pend_addr=0.
  - Outputs during reset: inst_sram_en=0, if_to_id_bus={1'b0,RESET_PC}, fetch_adel=0.
- ce_r: set to 1 on the first rising edge after reset release; stays 1 until the next reset.
- Three states, derived from ce_r and pend_v:
  - IDLE (ce_r=0): first edge goes to RUN, and the PC advances to RESET_PC+4 unless stall[0]=1.
  - RUN (ce_r=1, pend_v=0).
  - HOLD_PEND (pend_v=1).
- Next-PC rule, evaluated on every edge with ce state as above:
  - stall[0]=1: pc_r holds. If br_e=1, set pend_v=1 and pend_addr=br_addr; the latest branch wins if several arrive during one stall. If br_e=0, pend_v and pend_addr hold.
  - stall[0]=0, br_e=1: pc_r=br_addr, pend_v=0. A live branch beats a pending one.
  - stall[0]=0, br_e=0, pend_v=1: pc_r=pend_addr, pend_v=0.
  - Otherwise: pc_r=pc_r+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Delay slot: the branch is resolved in ID while its delay slot is already at pc_r, so the redirect takes effect on the next edge. No instruction is squashed here.
- SRAM port, combinational from registers:
  - inst_sram_addr=pc_r.
  - inst_sram_en=ce_r & ~fetch_adel & ~stall[0].
  - wen=0, wdata=0.
  - Read data returns one cycle later, aligned with ID's latched copy of if_to_id_bus.
- fetch_adel=ce_r & (pc_r[1:0]!=2'b00). The PC still advances normally; exception handling belongs downstream.
- if_to_id_bus={ce_r, pc_r}. Zero latency from the registers.
- br_bus is ignored while ce_r=0.

Test Plan:
- Reset release, no stall, no branch, 4 cycles -> inst_sram_addr = BFBF_FFFC (en=0), BFC0_0000, BFC0_0004, BFC0_0008 (en=1); if_to_id_bus ce 0,1,1,1.
- At pc BFC0_0010, br_bus={1,BFC0_0100} for one cycle, no stall -> next addr BFC0_0100, then BFC0_0104.
- stall[0]=1 for 3 cycles at pc BFC0_0020 with br {1,BFC0_0400} in the 2nd cycle:
  - addr holds BFC0_0020 and en=0 throughout the stall.
  - After release, addr is BFC0_0400, then BFC0_0404.
- During a stall, br to 0x1000 then br to 0x2000; on release br_e=1 to 0x3000 the same cycle -> addr 0x3000, pend_v cleared; the following edge gives 0x3004.
- Branch to BFC0_0102 -> fetch_adel=1, inst_sram_en=0; next cycle addr BFC0_0106 with fetch_adel still 1.
- rst_n asserted mid-stall with pend_v=1 -> pc and outputs return to reset values immediately; after release, fetch resumes at BFC0_0000 with no stale redirect.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives
// the instruction SRAM read port and produces the IF-to-ID bus. A redirect
// that ID resolves while IF is stalled goes into a pending latch, so the
// redirect is still applied once the stall releases.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst_n            asynchronous active-low reset
//   stall            global stall vector; bit 0 (Stop) freezes the PC
//   br_bus           {br_e, br_addr[31:0]} taken branch/jump from ID
//   inst_sram_en     SRAM read enable
//   inst_sram_wen    SRAM byte write enables (always 0, read-only port)
//   inst_sram_addr   SRAM address, equal to the current PC
//   inst_sram_wdata  SRAM write data (always 0)
//   if_to_id_bus     {ce, pc[31:0]}, sampled by ID on the next edge
//   fetch_adel       current PC is not word aligned
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int          STALL_WD = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [STALL_WD-1:0] stall,
    input  logic [32:0]         br_bus,
    output logic                inst_sram_en,
    output logic [3:0]          inst_sram_wen,
    output logic [31:0]         inst_sram_addr,
    output logic [31:0]         inst_sram_wdata,
    output logic [32:0]         if_to_id_bus,
    output logic                fetch_adel
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,  // ce_q = 0: first edge after reset release
        ST_RUN       = 2'd1,  // fetching, no redirect pending
        ST_HOLD_PEND = 2'd2   // a redirect captured during a stall is waiting
    } fetch_state_e;

    logic [31:0]  pc_q,        pc_d;
    logic         ce_q,        ce_d;
    logic         pend_v_q,    pend_v_d;
    logic [31:0]  pend_addr_q, pend_addr_d;
    fetch_state_e state;

    logic        stop;
    logic        br_e;
    logic [31:0] br_addr;

    assign stop    = stall[0];
    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // Only the Stop bit concerns fetch. The other stall bits go to later stages.
    logic unused_stall_hi;
    assign unused_stall_hi = &{1'b0, stall[STALL_WD-1:1]};

    // The state is decoded from the architectural registers rather than
    // stored separately, so it can never disagree with ce_q or pend_v_q.
    always_comb begin
        if (!ce_q) begin
            state = ST_IDLE;
        end else if (pend_v_q) begin
            state = ST_HOLD_PEND;
        end else begin
            state = ST_RUN;
        end
    end

    // Next-PC and pending-redirect logic.
    always_comb begin
        // NOTE: every output of this block gets a default first. Any path that
        // leaves a signal unassigned would otherwise infer a latch.
        pc_d        = pc_q;
        ce_d        = 1'b1;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;

        unique case (state)
            ST_IDLE: begin
                // br_bus is not trusted before the first fetch, so it is ignored.
                if (!stop) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            default: begin
                if (stop) begin
                    // The PC stays frozen. The newest branch replaces any older pending one.
                    if (br_e) begin
                        pend_v_d    = 1'b1;
                        pend_addr_d = br_addr;
                    end
                end else if (br_e) begin
                    // A live branch comes from a newer ID decision, so it beats the pending one.
                    pc_d     = br_addr;
                    pend_v_d = 1'b0;
                end else if (state == ST_HOLD_PEND) begin
                    pc_d     = pend_addr_q;
                    pend_v_d = 1'b0;
                end else begin
                    pc_d = pc_q + 32'd4;  // wraps modulo 2^32
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every flop updating from the values it had before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Outputs are decoded straight from the registers. They add no latency.
    // The PC keeps advancing after a misaligned fetch, and the exception
    // itself is handled downstream.
    assign fetch_adel      = ce_q & (pc_q[1:0] != 2'b00);
    assign inst_sram_en    = ce_q & ~fetch_adel & ~stop;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign if_to_id_bus    = {ce_q, pc_q};

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Bench for if_fetch_stage. It runs directed scenarios first, then random
// stall, branch and reset traffic. A reference model predicts the fetch
// address stream. It keeps redirects seen during a stall in a queue, and the
// newest one is used when the stall releases.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
    localparam int          STALL_WD = 6;

    logic                clk;
    logic                rst_n;
    logic [STALL_WD-1:0] stall;
    logic [32:0]         br_bus;
    logic                inst_sram_en;
    logic [3:0]          inst_sram_wen;
    logic [31:0]         inst_sram_addr;
    logic [31:0]         inst_sram_wdata;
    logic [32:0]         if_to_id_bus;
    logic                fetch_adel;

    if_fetch_stage #(.RESET_PC(RESET_PC), .STALL_WD(STALL_WD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .br_bus          (br_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .if_to_id_bus    (if_to_id_bus),
        .fetch_adel      (fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] pend_q[$];
    logic        cur_stop;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_ce = 1'b0;
        pend_q.delete();
    endtask

    // Behaviour of one rising edge.
    task automatic model_edge(input logic stp, input logic be, input logic [31:0] ba);
        if (!m_ce) begin
            m_ce = 1'b1;
            if (!stp) m_pc = m_pc + 32'd4;
        end else if (stp) begin
            if (be) pend_q.push_back(ba);
        end else begin
            if (be)                    m_pc = ba;
            else if (pend_q.size() > 0) m_pc = pend_q[$];
            else                        m_pc = m_pc + 32'd4;
            pend_q.delete();
        end
    endtask

    task automatic check_model(input string tag);
        logic adel_exp;
        adel_exp = m_ce & (m_pc[1:0] != 2'b00);
        chk({tag, ".addr"},  {1'b0, inst_sram_addr}, {1'b0, m_pc});
        chk({tag, ".bus"},   if_to_id_bus, {m_ce, m_pc});
        chk({tag, ".adel"},  {32'b0, fetch_adel}, {32'b0, adel_exp});
        chk({tag, ".en"},    {32'b0, inst_sram_en}, {32'b0, m_ce & ~adel_exp & ~cur_stop});
        chk({tag, ".wen"},   {29'b0, inst_sram_wen}, 33'h0);
        chk({tag, ".wdata"}, {1'b0, inst_sram_wdata}, 33'h0);
    endtask

    // Drive the inputs, take one rising edge, then check 1 time unit later.
    task automatic step(input string tag, input logic stp, input logic be,
                        input logic [31:0] ba);
        logic [STALL_WD-1:0] s;
        s        = STALL_WD'($urandom);
        s[0]     = stp;
        stall    = s;
        br_bus   = {be, ba};
        cur_stop = stp;
        @(posedge clk);
        model_edge(stp, be, ba);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset_and_release(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model({tag, ".in_reset"});
        chk({tag, ".rst_bus"}, if_to_id_bus, {1'b0, RESET_PC});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model({tag, ".released"});
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = '0;
        br_bus   = '0;
        cur_stop = 1'b0;
        model_reset();

        // Values held during reset, then the first fetches.
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.en_const", {32'b0, inst_sram_en}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFBF_FFFC});
        step("boot1", 1'b0, 1'b0, 32'h0);
        chk("boot1.bus_const", if_to_id_bus, {1'b1, 32'hBFC0_0000});
        chk("boot1.en_const", {32'b0, inst_sram_en}, 33'h1);
        step("boot2", 1'b0, 1'b0, 32'h0);
        step("boot3", 1'b0, 1'b0, 32'h0);
        chk("boot3.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0008});
        step("seq4", 1'b0, 1'b0, 32'h0);
        step("seq5", 1'b0, 1'b0, 32'h0);
        chk("seq5.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0010});

        // Taken branch with no stall.
        step("br", 1'b0, 1'b1, 32'hBFC0_0100);
        chk("br.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0100});
        step("br_next", 1'b0, 1'b0, 32'h0);
        chk("br_next.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});

        // A branch arriving during a three-cycle stall is kept until release.
        step("to20", 1'b0, 1'b1, 32'hBFC0_0020);
        step("st1", 1'b1, 1'b0, 32'h0);
        step("st2", 1'b1, 1'b1, 32'hBFC0_0400);
        step("st3", 1'b1, 1'b0, 32'h0);
        chk("st3.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0020});
        chk("st3.en_const", {32'b0, inst_sram_en}, 33'h0);
        step("st_rel", 1'b0, 1'b0, 32'h0);
        chk("st_rel.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0400});
        step("st_rel2", 1'b0, 1'b0, 32'h0);
        chk("st_rel2.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0404});

        // The newest pending branch wins, and a live branch at release beats it.
        step("pl1", 1'b1, 1'b1, 32'h0000_1000);
        step("pl2", 1'b1, 1'b1, 32'h0000_2000);
        step("pl_live", 1'b0, 1'b1, 32'h0000_3000);
        chk("pl_live.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'h0000_3000});
        step("pl_next", 1'b0, 1'b0, 32'h0);
        chk("pl_next.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'h0000_3004});

        // A misaligned target raises fetch_adel and gates en, and the PC still advances.
        step("mis", 1'b0, 1'b1, 32'hBFC0_0102);
        chk("mis.adel_const", {32'b0, fetch_adel}, 33'h1);
        chk("mis.en_const", {32'b0, inst_sram_en}, 33'h0);
        step("mis2", 1'b0, 1'b0, 32'h0);
        chk("mis2.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0106});
        chk("mis2.adel_const", {32'b0, fetch_adel}, 33'h1);

        // The PC wraps modulo 2^32.
        step("wrap0", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap1", 1'b0, 1'b0, 32'h0);
        chk("wrap1.addr_const", {1'b0, inst_sram_addr}, 33'h0);

        // Asynchronous reset mid-stall with a redirect pending.
        step("rp1", 1'b1, 1'b1, 32'h0000_5000);
        step("rp2", 1'b1, 1'b0, 32'h0);
        #1;
        do_reset_and_release("rst_mid");
        step("rp_boot", 1'b0, 1'b0, 32'h0);
        chk("rp_boot.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
        step("rp_boot2", 1'b0, 1'b0, 32'h0);
        chk("rp_boot2.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0004});

        // A stall on the first edge after reset holds the PC, and br_bus is ignored.
        #1;
        do_reset_and_release("rst_idle");
        step("idle_st", 1'b1, 1'b1, 32'h0000_7000);
        chk("idle_st.bus_const", if_to_id_bus, {1'b1, 32'hBFBF_FFFC});
        step("idle_go", 1'b0, 1'b0, 32'h0);
        chk("idle_go.addr_const", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});

        // Random traffic checked against the model.
        for (int i = 0; i < 400; i++) begin
            logic        stp;
            logic        be;
            logic [31:0] ba;
            if ($urandom_range(0, 59) == 0) begin
                #1;
                do_reset_and_release("rnd_rst");
            end
            stp = ($urandom_range(0, 9) < 3);
            be  = ($urandom_range(0, 3) == 0);
            ba  = $urandom;
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            if ($urandom_range(0, 31) == 0) ba = 32'hFFFF_FFFC;
            step("rnd", stp, be, ba);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
